riscv_lsu: RTL and testbench

- Parametrised load/store unit between the CPU datapath and the data-memory/IO bus.
- Accepts one RV32I load or store per handshake and drives a word-aligned bus access with byte enables.
- Waits a variable number of cycles for the memory/IO acknowledge, then returns sign- or zero-extended load data.
- Flags misaligned accesses, illegal funct3 and bus timeouts; replaces the single-cycle combinational data path with a wait-state-tolerant sequential one.

---
 rtl/riscv_lsu.sv | 149 ++++++++++++++
 tb/tb_riscv_lsu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one access per handshake, word-aligned bus cycle with byte
// enables, wait-state tolerant with optional timeout, and sign/zero-extended load return.
module riscv_lsu #(
   parameter int ADDR_W        = 32,
   parameter int TIMEOUT       = 15,
   parameter int MISALIGN_TRAP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both
   // high; resp_valid is a single-cycle pulse that needs no ready; mem_req is held until
   // mem_ack (sampled only while mem_req is high) or the timeout.
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [2:0]        f3_q;
   logic              we_q;
   logic [1:0]        lane_q;

   logic              illegal, misal;
   logic [1:0]        sz;
   logic [ADDR_W-1:0] eff_addr;
   logic [3:0]        be_d;
   logic [31:0]       wdata_d, lane, ld_data;

   assign req_ready = (state == IDLE) && rst;
   assign dbg_state = state;

   always_comb begin
      sz       = req_funct3[1:0];
      illegal  = req_we ? (req_funct3 > 3'd2)
                        : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      misal    = (sz == 2'd1 && req_addr[0]) || (sz == 2'd2 && req_addr[1:0] != 2'b00);
      // When not trapping, misaligned addresses are rounded down to natural alignment.
      eff_addr = req_addr;
      if (sz == 2'd1) eff_addr[0] = 1'b0;
      if (sz == 2'd2) eff_addr[1:0] = 2'b00;
      case (sz)
         2'd0:    be_d = 4'b0001 << eff_addr[1:0];
         2'd1:    be_d = 4'b0011 << {eff_addr[1], 1'b0};
         default: be_d = 4'b1111;
      endcase
      case (sz)
         2'd0:    wdata_d = {4{req_wdata[7:0]}};
         2'd1:    wdata_d = {2{req_wdata[15:0]}};
         default: wdata_d = req_wdata;
      endcase
      if (!req_we) wdata_d = 32'd0;
   end

   always_comb begin
      lane = mem_rdata >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ld_data = {24'd0, lane[7:0]};
         3'b101:  ld_data = {16'd0, lane[15:0]};
         default: ld_data = lane;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         f3_q       <= 3'd0;
         we_q       <= 1'b0;
         lane_q     <= 2'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= 4'd0;
         mem_wdata  <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  f3_q   <= req_funct3;
                  we_q   <= req_we;
                  lane_q <= eff_addr[1:0];
                  if (illegal || (misal && MISALIGN_TRAP != 0)) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state     <= ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {eff_addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= be_d;
                     mem_wdata <= wdata_d;
                     wait_cnt  <= '0;
                  end
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= we_q ? 32'd0 : ld_data;
               end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'd0;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: trapping instance with a response scoreboard, plus a
// non-trapping instance for the alignment-forcing path.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_valid2 = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic        mem_ack = 1'b0, mem_ack2 = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [1:0]  dbg_state;

   logic        req_ready2, resp_valid2, resp_err2, mem_req2, mem_we2;
   logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
   logic [3:0]  mem_be2;
   logic [1:0]  dbg_state2;

   int          total = 0, bad = 0;
   int          hi_cnt = 0, resp_cnt = 0;
   int          hi0, r0;
   logic [32:0] exp_q[$];
   logic [32:0] e;

   riscv_lsu #(.ADDR_W(32), .TIMEOUT(15), .MISALIGN_TRAP(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   riscv_lsu #(.ADDR_W(32), .TIMEOUT(15), .MISALIGN_TRAP(0)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
      .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_be(mem_be2),
      .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata), .dbg_state(dbg_state2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic both);
      chk("req_ready_before", {31'd0, req_ready}, 32'd1);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid = 1'b1; req_valid2 = both;
      cyc();
      req_valid = 1'b0; req_valid2 = 1'b0;
   endtask

   task automatic ack_after(input int w, input logic [31:0] d);
      for (int i = 0; i < w; i++) cyc();
      mem_rdata = d; mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
   endtask

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   // Scoreboard: every resp_valid pulse pops one expected {err, rdata}.
   always @(negedge clk) begin
      if (mem_req) hi_cnt++;
      if (resp_valid) begin
         resp_cnt++;
         chk("resp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
            chk("resp_rdata", resp_rdata, e[31:0]);
         end
      end
   end

   task automatic load_check(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic [3:0] exp_be, input int w);
      exp_q.push_back({1'b0, exp_rd});
      do_req(1'b0, f3, a, 32'hFFFF_FFFF, 1'b0);
      chk("ld_mem_req", {31'd0, mem_req}, 32'd1);
      chk("ld_mem_be", {28'd0, mem_be}, {28'd0, exp_be});
      chk("ld_mem_wdata", mem_wdata, 32'd0);
      ack_after(w, d);
      chk("ld_resp_valid", {31'd0, resp_valid}, 32'd1);
      cyc();
   endtask

   initial begin
      logic [2:0]  f3;
      logic [1:0]  a;
      logic [31:0] d;
      int          w;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      rst = 1'b1;
      cyc();

      // LW zero-wait
      hi0 = hi_cnt;
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
      chk("lw_mem_req", {31'd0, mem_req}, 32'd1);
      chk("lw_mem_addr", mem_addr, 32'h100);
      chk("lw_mem_be", {28'd0, mem_be}, 32'hF);
      chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
      chk("lw_ready_busy", {31'd0, req_ready}, 32'd0);
      ack_after(0, 32'hDEAD_BEEF);
      chk("lw_resp_n2", {31'd0, resp_valid}, 32'd1);
      chk("lw_mem_req_off", {31'd0, mem_req}, 32'd0);
      cyc();
      chk("lw_resp_pulse", {31'd0, resp_valid}, 32'd0);
      chk("lw_hi_cycles", 32'(hi_cnt - hi0), 32'd1);

      load_check(3'b000, 32'h103, 32'h80FF_7F01, 32'hFFFF_FF80, 4'b1000, 0);
      load_check(3'b100, 32'h103, 32'h80FF_7F01, 32'h0000_0080, 4'b1000, 1);
      load_check(3'b001, 32'h102, 32'h80FF_7F01, 32'hFFFF_80FF, 4'b1100, 2);
      chk("rdata_hold", resp_rdata, 32'hFFFF_80FF);

      // SB with three wait states
      hi0 = hi_cnt;
      exp_q.push_back({1'b0, 32'd0});
      do_req(1'b1, 3'b000, 32'h4001, 32'h0000_00A5, 1'b0);
      chk("sb_mem_be", {28'd0, mem_be}, 32'b0010);
      chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("sb_mem_addr", mem_addr, 32'h4000);
      chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
      ack_after(3, 32'h1234_5678);
      chk("sb_resp", {31'd0, resp_valid}, 32'd1);
      cyc();
      chk("sb_hi_cycles", 32'(hi_cnt - hi0), 32'd4);

      // Misaligned SW: trap on dut, forced alignment on dut2
      hi0 = hi_cnt;
      exp_q.push_back({1'b1, 32'd0});
      do_req(1'b1, 3'b010, 32'h102, 32'h1234_5678, 1'b1);
      chk("mis_no_mem_req", {31'd0, mem_req}, 32'd0);
      chk("mis_resp_n1", {31'd0, resp_valid}, 32'd1);
      chk("nt_mem_req", {31'd0, mem_req2}, 32'd1);
      chk("nt_mem_addr", mem_addr2, 32'h100);
      chk("nt_mem_be", {28'd0, mem_be2}, 32'hF);
      chk("nt_mem_wdata", mem_wdata2, 32'h1234_5678);
      mem_ack2 = 1'b1;
      cyc();
      mem_ack2 = 1'b0;
      chk("nt_resp_valid", {31'd0, resp_valid2}, 32'd1);
      chk("nt_resp_err", {31'd0, resp_err2}, 32'd0);
      cyc();
      chk("mis_hi_cycles", 32'(hi_cnt - hi0), 32'd0);

      // Illegal funct3 load
      exp_q.push_back({1'b1, 32'd0});
      do_req(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
      chk("ill_no_mem_req", {31'd0, mem_req}, 32'd0);
      cyc();

      // Timeout, then ack on the last allowed cycle
      hi0 = hi_cnt;
      exp_q.push_back({1'b1, 32'd0});
      do_req(1'b0, 3'b010, 32'h200, 32'h0, 1'b0);
      for (int i = 0; i < 15; i++) cyc();
      chk("to_resp", {31'd0, resp_valid}, 32'd1);
      cyc();
      chk("to_hi_cycles", 32'(hi_cnt - hi0), 32'd15);
      hi0 = hi_cnt;
      exp_q.push_back({1'b0, 32'h1122_3344});
      do_req(1'b0, 3'b010, 32'h200, 32'h0, 1'b0);
      ack_after(14, 32'h1122_3344);
      chk("ack15_resp", {31'd0, resp_valid}, 32'd1);
      cyc();
      chk("ack15_hi_cycles", 32'(hi_cnt - hi0), 32'd15);

      // Random aligned loads with random wait states
      for (int k = 0; k < 6; k++) begin
         case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
         endcase
         a = (f3[1:0] == 2'd2) ? 2'd0 :
             (f3[1:0] == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
         d = $urandom;
         w = $urandom_range(0, 4);
         exp_q.push_back({1'b0, ld_model(f3, a, d)});
         do_req(1'b0, f3, {28'h000_0060, 2'b00, a}, 32'h0, 1'b0);
         ack_after(w, d);
         chk("rnd_resp", {31'd0, resp_valid}, 32'd1);
         cyc();
      end

      // Reset in the middle of an access
      r0 = resp_cnt;
      do_req(1'b0, 3'b010, 32'h300, 32'h0, 1'b0);
      cyc();
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      cyc();
      chk("rst_mid_no_resp", 32'(resp_cnt - r0), 32'd0);
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      load_check(3'b010, 32'h304, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF, 1);

      cyc();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
